// File: rtl/parity_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parity_engine_pkg
//  Description : Shared definitions for the parity engine. Contains the FSM
//                state encodings and helpers that size the ones-count and
//                beat-counter registers.
//  Revision    : 1.0 - initial release
// ============================================================================
package parity_engine_pkg;

    // FSM state encodings. Encoding 2'd3 is unused and recovers to IDLE.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Width needed to hold a ones count of 0..data_w.
    function automatic int calc_cw(input int data_w);
        return $clog2(data_w + 1);
    endfunction

    // Beat counter width; at least one bit even for a single-beat scan.
    function automatic int calc_bw(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage : parity_engine_pkg
`default_nettype wire

// File: rtl/parity_popcount.sv
`default_nettype none
// ============================================================================
//  Module      : parity_popcount
//  Description : Combinational population count of a W-bit slice.
//  Ports       : bits  (in,  W)              - slice to count
//                count (out, $clog2(W+1))    - number of ones in bits
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_popcount #(
    parameter int W = 1,
    localparam int CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     bits,
    output logic [CNT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CNT_W'(bits[i]);
        end
    end

endmodule : parity_popcount
`default_nettype wire

// File: rtl/parity_engine.sv
`default_nettype none
// ============================================================================
//  Module      : parity_engine
//  Description : Multi-cycle parity engine. Captures a DATA_W-bit word on
//                start, consumes BITS_PER_CYCLE bits per clock while
//                accumulating a ones count, then reports parity results with
//                a one-cycle done pulse.
//  Config      : PARITY_ENGINE_CHECK_EN - when defined, compares the computed
//                parity against expected_parity and drives parity_err;
//                otherwise parity_err is tied low.
//  Ports       : clk, rst (sync, active-high)
//                start, data_in[DATA_W], expected_parity  - request side
//                busy, done                               - handshake
//                even_parity, odd_parity, ones_count[CW],
//                parity_err                               - results
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_engine
    import parity_engine_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int BITS_PER_CYCLE = 1,
    localparam int CW            = calc_cw(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic              expected_parity,
    output logic              busy,
    output logic              done,
    output logic              even_parity,
    output logic              odd_parity,
    output logic [CW-1:0]     ones_count,
    output logic              parity_err
);

    localparam int N  = DATA_W / BITS_PER_CYCLE;
    localparam int BW = calc_bw(N);
    localparam int PW = $clog2(BITS_PER_CYCLE + 1);

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_shift;
    logic [CW-1:0]     r_acc;
    logic [BW-1:0]     r_beat;
    logic              r_busy;
    logic              r_done;
    logic              r_even;
    logic              r_odd;
    logic [CW-1:0]     r_ones;
    logic [PW-1:0]     w_pop;

    parity_popcount #(
        .W (BITS_PER_CYCLE)
    ) u_popcount (
        .bits  (r_shift[BITS_PER_CYCLE-1:0]),
        .count (w_pop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_acc   <= '0;
            r_beat  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_even  <= 1'b0;
            r_odd   <= 1'b0;
            r_ones  <= '0;
        end else begin
            // done is a single-cycle pulse; only the DONE branch raises it.
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shift <= data_in;
                        r_acc   <= '0;
                        r_beat  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    r_acc   <= r_acc + CW'(w_pop);
                    r_shift <= r_shift >> BITS_PER_CYCLE;
                    r_beat  <= r_beat + BW'(1);
                    if (r_beat == BW'(N - 1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_ones  <= r_acc;
                    r_odd   <= r_acc[0];
                    r_even  <= ~r_acc[0];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef PARITY_ENGINE_CHECK_EN
    logic r_exp;
    logic r_err;

    // Expected parity is captured alongside the word and compared once the
    // full count is known.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exp <= 1'b0;
            r_err <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_exp <= expected_parity;
        end else if (r_state == DONE) begin
            r_err <= r_acc[0] ^ r_exp;
        end
    end

    assign parity_err = r_err;
`else
    // expected_parity is kept on the port list for a uniform interface.
    logic w_unused_expected;
    assign w_unused_expected = expected_parity;
    assign parity_err        = 1'b0;
`endif

    assign busy        = r_busy;
    assign done        = r_done;
    assign even_parity = r_even;
    assign odd_parity  = r_odd;
    assign ones_count  = r_ones;

endmodule : parity_engine
`default_nettype wire

// File: tb/tb_parity_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parity_engine
//  Description : Self-checking bench for parity_engine. Two instances:
//                8-bit / 1 bit per cycle and 16-bit / 4 bits per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_engine;

    logic        clk;
    logic        rst;

    logic        start8, exp8;
    logic [7:0]  data8;
    logic        busy8, done8, even8, odd8, err8;
    logic [3:0]  ones8;

    logic        start16, exp16;
    logic [15:0] data16;
    logic        busy16, done16, even16, odd16, err16;
    logic [4:0]  ones16;

    int checks;
    int failures;

`ifdef PARITY_ENGINE_CHECK_EN
    localparam logic c_err_on = 1'b1;
`else
    localparam logic c_err_on = 1'b0;
`endif

    parity_engine #(.DATA_W(8), .BITS_PER_CYCLE(1)) u_dut8 (
        .clk             (clk),
        .rst             (rst),
        .start           (start8),
        .data_in         (data8),
        .expected_parity (exp8),
        .busy            (busy8),
        .done            (done8),
        .even_parity     (even8),
        .odd_parity      (odd8),
        .ones_count      (ones8),
        .parity_err      (err8)
    );

    parity_engine #(.DATA_W(16), .BITS_PER_CYCLE(4)) u_dut16 (
        .clk             (clk),
        .rst             (rst),
        .start           (start16),
        .data_in         (data16),
        .expected_parity (exp16),
        .busy            (busy16),
        .done            (done16),
        .even_parity     (even16),
        .odd_parity      (odd16),
        .ones_count      (ones16),
        .parity_err      (err16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Advance past the next rising edge; outputs then reflect that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done8(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!done8 && cyc < 50);
    endtask

    task automatic wait_done16(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!done16 && cyc < 50);
    endtask

    // Start an 8-bit operation and wait for its done pulse.
    task automatic run8(input logic [7:0] d, input logic e, output int cyc);
        data8  = d;
        exp8   = e;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        wait_done8(cyc);
    endtask

    initial begin
        int cyc;
        int pulses;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start8   = 1'b0; data8  = '0; exp8  = 1'b0;
        start16  = 1'b0; data16 = '0; exp16 = 1'b0;

        // ---- reset with random inputs ----
        for (int i = 0; i < 2; i++) begin
            start8  = 1'($urandom);  data8  = 8'($urandom);  exp8  = 1'($urandom);
            start16 = 1'($urandom);  data16 = 16'($urandom); exp16 = 1'($urandom);
            tick();
            check("rst_busy8", busy8, 0);
            check("rst_done8", done8, 0);
            check("rst_res8", {even8, odd8, err8, ones8}, 0);
            check("rst_busy16", busy16, 0);
            check("rst_res16", {done16, even16, odd16, err16, ones16}, 0);
        end
        rst = 1'b0; start8 = 1'b0; start16 = 1'b0;
        tick();

        // ---- 8'hA5: busy window and result timing ----
        data8 = 8'hA5; exp8 = 1'b0; start8 = 1'b1;
        tick();                                    // accepting edge k
        start8 = 1'b0;
        data8  = 8'hFF;                            // must not affect result
        check("a5_busy_k", busy8, 1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("a5_busy_scan", busy8, 1);
            check("a5_nodone_scan", done8, 0);
        end
        tick();                                    // edge k+9
        check("a5_done", done8, 1);
        check("a5_busy_low", busy8, 0);
        check("a5_ones", ones8, 4);
        check("a5_even", even8, 1);
        check("a5_odd", odd8, 0);
        tick();
        check("a5_done_clr", done8, 0);
        check("a5_hold", ones8, 4);

        // ---- back-to-back 8'h07 then 8'h00 ----
        run8(8'h07, 1'b1, cyc);
        check("b2b1_lat", cyc, 9);
        check("b2b1_ones", ones8, 3);
        check("b2b1_odd", odd8, 1);
        check("b2b1_even", even8, 0);
        data8 = 8'h00; start8 = 1'b1;              // start during done cycle
        tick();
        start8 = 1'b0;
        check("b2b2_acc", busy8, 1);
        wait_done8(cyc);
        check("b2b2_lat", cyc + 1, 10);
        check("b2b2_ones", ones8, 0);
        check("b2b2_even", even8, 1);

        // ---- 16-bit, 4 bits per cycle ----
        data16 = 16'hFFFF; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        wait_done16(cyc);
        check("w16_lat", cyc, 5);
        check("w16_ones", ones16, 16);
        check("w16_even", even16, 1);
        check("w16_odd", odd16, 0);
        data16 = 16'h8001; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        wait_done16(cyc);
        check("w16b_lat", cyc, 5);
        check("w16b_ones", ones16, 2);
        check("w16b_even", even16, 1);

        // ---- mid-SCAN start ignored, reset at beat 3 aborts ----
        data8 = 8'hFF; start8 = 1'b1;
        tick();                                    // edge k, beat 0
        start8 = 1'b0;
        tick();                                    // k+1
        data8 = 8'h01; start8 = 1'b1;
        tick();                                    // k+2, start ignored
        start8 = 1'b0;
        check("mid_busy", busy8, 1);
        tick();                                    // k+3, beat 3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy8, 0);
        check("abort_res", {done8, even8, odd8, err8, ones8}, 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) pulses++;
        end
        check("abort_nodone", pulses, 0);
        run8(8'h03, 1'b0, cyc);                    // FSM must be idle
        check("abort_idle_lat", cyc, 9);
        check("abort_idle_ones", ones8, 2);

        // ---- parity error compare ----
        run8(8'h01, 1'b0, cyc);
        check("err_exp0", err8, c_err_on);
        check("err_exp0_odd", odd8, 1);
        run8(8'h01, 1'b1, cyc);
        check("err_exp1", err8, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_parity_engine
`default_nettype wire
